// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter and its neighbours.
package mem_arb_pkg;

   // Which requester owns the access that was granted last cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LD   = 2'd2,
      OWN_ST   = 2'd3
   } mem_owner_e;

   // Base of the unified memory image, shared with fetch and memory.
   localparam logic [31:0] BASE_ADDR = 32'h0100_0000;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive cycles in which fetch was denied the port.
module arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int             W   = $clog2(LIMIT + 1);
   localparam logic [W-1:0]   LIM = W'(LIMIT);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear wins over increment; increment holds once the limit is reached.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != LIM)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register, cleared immediately by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory read/write port between instruction fetch and load/store,
// tracks the owner of the in-flight access and routes its response back.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AWIDTH       = 32,
   parameter int DWIDTH       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [AWIDTH-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rsp_valid_o,
   output logic [DWIDTH-1:0] if_rdata_o,
   input  logic              ls_req_i,
   input  logic              ls_we_i,
   input  logic [AWIDTH-1:0] ls_addr_i,
   input  logic [DWIDTH-1:0] ls_wdata_i,
   output logic              ls_gnt_o,
   output logic              ls_rsp_valid_o,
   output logic [DWIDTH-1:0] ls_rdata_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_data_o,
   output logic              mem_read_en_o,
   output logic              mem_write_en_o,
   input  logic [DWIDTH-1:0] mem_data_i
);

   mem_owner_e owner_q;
   mem_owner_e owner_d;
   logic       starve_at_limit;
   logic       if_win;

   arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk      (clk),
      .rst      (rst),
      .inc      (if_req_i & ls_gnt_o),
      .clr      (if_gnt_o | ~if_req_i),
      .at_limit (starve_at_limit)
   );

   // Pick this cycle's winner, drive the memory port from it and note the owner.
   // Grants are masked during reset so every output is quiet while rst is high.
   always_comb begin
      if_win         = if_req_i & (~ls_req_i | starve_at_limit);
      if_gnt_o       = if_win & ~rst;
      ls_gnt_o       = ls_req_i & ~if_win & ~rst;
      mem_addr_o     = '0;
      mem_data_o     = '0;
      mem_read_en_o  = 1'b0;
      mem_write_en_o = 1'b0;
      owner_d        = OWN_NONE;
      if (if_gnt_o) begin
         mem_addr_o    = if_addr_i;
         mem_read_en_o = 1'b1;
         owner_d       = OWN_IF;
      end else if (ls_gnt_o) begin
         mem_addr_o = ls_addr_i;
         if (ls_we_i) begin
            mem_data_o     = ls_wdata_i;
            mem_write_en_o = 1'b1;
            owner_d        = OWN_ST;
         end else begin
            mem_read_en_o = 1'b1;
            owner_d       = OWN_LD;
         end
      end
   end

   // Owner of the access whose response arrives next cycle; reset drops it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   // Steer the one-cycle-late memory data to the requester that owns it.
   always_comb begin
      if_rsp_valid_o = 1'b0;
      if_rdata_o     = '0;
      ls_rsp_valid_o = 1'b0;
      ls_rdata_o     = '0;
      case (owner_q)
         OWN_IF: begin
            if_rsp_valid_o = 1'b1;
            if_rdata_o     = mem_data_i;
         end
         OWN_LD: begin
            ls_rsp_valid_o = 1'b1;
            ls_rdata_o     = mem_data_i;
         end
         OWN_ST: begin
            ls_rsp_valid_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
